dsp_group_ctrl: RTL and testbench
=================================

DSP_GROUP_CTRL -- requirements
Module: dsp_group_ctrl

Interface
REQ-001 SHALL have parameter N_KERNEL, default 3, number of kernel lanes in the DSP group.
REQ-002 SHALL have parameter B_PIXEL, default 16, pixel/weight width; product width is 2*B_PIXEL.
REQ-003 SHALL have parameter B_LEN, default 10, width of the dot-product length field.
REQ-004 SHALL have parameter LAT, default 5, cycles from issue to product on prod_i (1 buffer read + 4 DSP).
REQ-005 SHALL have parameter B_ACC, default 40, per-lane accumulator width.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rstn  in  1  reset, asynchronous, active-low.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  command accepted when both high.
REQ-010 cmd_len  in  B_LEN  number of MAC steps.
REQ-011 abort  in  1  synchronous cancel of current job.
REQ-012 buf_rd  out  1  read strobe to weight/feature buffers.
REQ-013 buf_addr  out  B_LEN  buffer read address.
REQ-014 dsp_clk_en  out  1  clock enable to the DSP group.
REQ-015 prod_i  in  2*B_PIXEL*N_KERNEL  per-lane signed products from the DSP group (its acc_i tied to zero).
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  result consumed when both high.
REQ-018 res_data  out  B_ACC*N_KERNEL  per-lane signed sums, lane j at [j*B_ACC +: B_ACC].

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN, HOLD.
REQ-020 IDLE: cmd_ready=1; on cmd_valid with cmd_len>0 latch len, clear addr, go ISSUE; with cmd_len==0 accept, set res_data=0, go HOLD.
REQ-021 ISSUE: buf_rd=1, buf_addr counts 0..len-1 one per cycle; after issuing len-1 go DRAIN.
REQ-022 Each issue cycle SHALL push a tag {valid, first, last} into a LAT-deep shift register; first on addr 0, last on addr len-1 (both on len==1).
REQ-023 dsp_clk_en SHALL be 1 in ISSUE and DRAIN, 0 in IDLE and HOLD; the tag pipe SHALL advance only when dsp_clk_en=1.
REQ-024 When a valid tag exits the pipe, each lane's prod_i SHALL be sign-extended to B_ACC and loaded into the accumulator if first, else added (two's complement wrap, no saturation).
REQ-025 DRAIN: when the last tag exits, the updated accumulator SHALL be registered into res_data and state SHALL go HOLD the next cycle.
REQ-026 Result latency SHALL be exactly len+LAT+1 cycles from command acceptance to res_valid=1.
REQ-027 HOLD: res_valid=1, res_data stable; on res_ready go IDLE; a new command is not accepted in the same cycle.
REQ-028 cmd_ready SHALL be 0 in every state except IDLE.
REQ-029 abort in ISSUE or DRAIN SHALL clear all tags, return to IDLE next cycle, produce no result; abort in IDLE or HOLD SHALL be ignored.
REQ-030 abort and the last-tag exit in the same cycle: abort SHALL win, no result.
REQ-031 buf_addr SHALL hold its last value outside ISSUE.

Reset
REQ-032 While rstn=0: state IDLE, cmd_ready=0, buf_rd=0, buf_addr=0, dsp_clk_en=0, res_valid=0, res_data=0, tag pipe and accumulators cleared.
REQ-033 cmd_ready SHALL rise the first cycle after rstn deasserts.
REQ-034 Reset mid-job SHALL discard the job; no result after release.

Verification
REQ-035 len=4, lane0 products 1,2,3,4, lane1 -1 each, lane2 0x7FFF_FFFF each -> res_valid at cycle 10 after accept, lanes 10, -4, 0x1_FFFF_FFFC.
REQ-036 len=1, product -5 on all lanes -> every lane -5 sign-extended, res_valid 7 cycles after accept.
REQ-037 len=0 -> accepted, res_valid next cycle, res_data=0, dsp_clk_en never high.
REQ-038 len=8, abort at 3rd issue cycle -> IDLE next cycle, no res_valid, next len=2 job returns correct sum.
REQ-039 res_ready held 0 for 20 cycles in HOLD -> res_data stable, cmd_ready=0, dsp_clk_en=0; on res_ready -> IDLE.
REQ-040 rstn pulsed low during DRAIN -> all outputs at reset values immediately, no result after release.

Source files
------------

// File: rtl/dsp_group_ctrl.sv
// dsp_group_ctrl: sequences one dot-product job through an N_KERNEL-lane DSP group.
// A command of cmd_len MAC steps is issued as buffer reads at one address per cycle.
// A tag pipe tracks each read until its products arrive LAT cycles later. Each lane
// sums its products into a wide accumulator, and the final sums are held until
// the consumer takes them.
module dsp_group_ctrl #(
  parameter int N_KERNEL = 3,
  parameter int B_PIXEL  = 16,
  parameter int B_LEN    = 10,
  parameter int LAT      = 5,
  parameter int B_ACC    = 40
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [B_LEN-1:0]                cmd_len,
  input  logic                            abort,
  output logic                            buf_rd,
  output logic [B_LEN-1:0]                buf_addr,
  output logic                            dsp_clk_en,
  input  logic [2*B_PIXEL*N_KERNEL-1:0]   prod_i,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [B_ACC*N_KERNEL-1:0]       res_data
);

  localparam int P_W = 2 * B_PIXEL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Low until the first edge after reset release; this keeps cmd_ready low while in reset.
  logic rdy_en;

  logic [B_LEN-1:0] len_q;
  logic [B_LEN-1:0] addr_q;

  // Tag pipe: index 0 is the newest tag. Index LAT-1 lines up with prod_i.
  logic [LAT-1:0] tag_vld_p;
  logic [LAT-1:0] tag_first_p;
  logic [LAT-1:0] tag_last_p;

  logic signed [B_ACC-1:0] acc_q   [N_KERNEL];
  logic signed [B_ACC-1:0] acc_nxt [N_KERNEL];

  logic accept;
  logic issue_last;
  logic kill;
  logic tag_exit;
  logic last_exit;

  // Sign-extend one lane product to accumulator width.
  function automatic logic signed [B_ACC-1:0] sext_prod(input logic signed [P_W-1:0] p);
    return B_ACC'(p);
  endfunction

  assign accept     = cmd_valid && cmd_ready;
  assign issue_last = (state == S_ISSUE) && (addr_q == len_q - 1'b1);
  assign kill       = abort && ((state == S_ISSUE) || (state == S_DRAIN));
  assign tag_exit   = dsp_clk_en && tag_vld_p[LAT-1];
  // An abort in the same cycle as the final exit cancels the result.
  assign last_exit  = tag_exit && tag_last_p[LAT-1] && !kill;
  assign buf_addr   = addr_q;

  // State register and post-reset ready enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (cmd_len == '0) ? S_HOLD : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (issue_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (last_exit) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake and DSP control outputs.
  always_comb begin
    cmd_ready  = (state == S_IDLE) && rdy_en;
    buf_rd     = (state == S_ISSUE);
    dsp_clk_en = (state == S_ISSUE) || (state == S_DRAIN);
    res_valid  = (state == S_HOLD);
  end

  // Job length latch and read address counter; the address holds outside ISSUE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q  <= '0;
      addr_q <= '0;
    end else if ((state == S_IDLE) && accept && (cmd_len != '0)) begin
      len_q  <= cmd_len;
      addr_q <= '0;
    end else if ((state == S_ISSUE) && !kill && !issue_last) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // ---- stage p0..p(LAT-1): tag pipe, advancing in step with the DSP clock enable ----
  // Tag pipe shifts only while the DSP group is enabled; an abort flushes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld_p   <= '0;
      tag_first_p <= '0;
      tag_last_p  <= '0;
    end else if (kill) begin
      tag_vld_p   <= '0;
      tag_first_p <= '0;
      tag_last_p  <= '0;
    end else if (dsp_clk_en) begin
      tag_vld_p[0]   <= (state == S_ISSUE);
      tag_first_p[0] <= (state == S_ISSUE) && (addr_q == '0);
      tag_last_p[0]  <= issue_last;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_p[i]   <= tag_vld_p[i-1];
        tag_first_p[i] <= tag_first_p[i-1];
        tag_last_p[i]  <= tag_last_p[i-1];
      end
    end
  end

  // ---- accumulate stage: products aligned with the exiting tag ----
  // Per-lane next accumulator: load on the first step, otherwise add with wraparound.
  always_comb begin
    for (int j = 0; j < N_KERNEL; j++) begin
      acc_nxt[j] = '0;
      if (tag_first_p[LAT-1]) begin
        acc_nxt[j] = sext_prod(prod_i[j*P_W +: P_W]);
      end else begin
        acc_nxt[j] = acc_q[j] + sext_prod(prod_i[j*P_W +: P_W]);
      end
    end
  end

  // Accumulators update whenever a live tag exits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N_KERNEL; j++) begin
        acc_q[j] <= '0;
      end
    end else if (tag_exit && !kill) begin
      for (int j = 0; j < N_KERNEL; j++) begin
        acc_q[j] <= acc_nxt[j];
      end
    end
  end

  // ---- result stage: sums captured on the final exit and held through HOLD ----
  // Result register: zero for an empty job, the final sums when the last tag exits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_data <= '0;
    end else if ((state == S_IDLE) && accept && (cmd_len == '0)) begin
      res_data <= '0;
    end else if (last_exit) begin
      for (int j = 0; j < N_KERNEL; j++) begin
        res_data[j*B_ACC +: B_ACC] <= acc_nxt[j];
      end
    end
  end

endmodule

// File: tb/tb_dsp_group_ctrl.sv
// Testbench for dsp_group_ctrl. A DSP stand-in returns per-address products LAT
// cycles after each buffer read. Jobs are randomized. Each job that should complete
// pushes its expected sums and due cycle into a scoreboard. A monitor checks every
// result handshake against that scoreboard.
module tb_dsp_group_ctrl;

  localparam int NK   = 3;
  localparam int BP   = 16;
  localparam int BL   = 10;
  localparam int LT   = 5;
  localparam int BA   = 40;
  localparam int PW   = 2 * BP;
  localparam int RW   = BA * NK;
  localparam int MAXL = 16;

  logic            clk;
  logic            rstn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [BL-1:0]   cmd_len;
  logic            abort;
  logic            buf_rd;
  logic [BL-1:0]   buf_addr;
  logic            dsp_clk_en;
  logic [PW*NK-1:0] prod_i;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_data;

  dsp_group_ctrl #(
    .N_KERNEL(NK), .B_PIXEL(BP), .B_LEN(BL), .LAT(LT), .B_ACC(BA)
  ) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .abort(abort), .buf_rd(buf_rd), .buf_addr(buf_addr),
    .dsp_clk_en(dsp_clk_en), .prod_i(prod_i), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  typedef struct {
    logic [RW-1:0] data;
    int            due;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic stall       = 1'b0;

  logic signed [PW-1:0] prodtab   [NK][MAXL];
  logic signed [PW-1:0] stage_tab [NK][MAXL];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: each lane is the plain two's-complement sum of its products.
  function automatic logic [RW-1:0] model(input int len);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < NK; j++) begin
      logic signed [BA-1:0] s;
      s = '0;
      for (int a = 0; a < len; a++) begin
        s = s + BA'(prodtab[j][a]);
      end
      r[j*BA +: BA] = s;
    end
    return r;
  endfunction

  // DSP stand-in: a read in cycle t returns its products during cycle t+LT.
  initial begin
    logic          hist_rd   [LT];
    logic [BL-1:0] hist_addr [LT];
    logic          pr;
    logic [BL-1:0] pa;
    for (int i = 0; i < LT; i++) begin
      hist_rd[i]   = 1'b0;
      hist_addr[i] = '0;
    end
    prod_i = '0;
    forever begin
      @(negedge clk);
      for (int i = LT - 1; i > 0; i--) begin
        hist_rd[i]   = hist_rd[i-1];
        hist_addr[i] = hist_addr[i-1];
      end
      hist_rd[0]   = buf_rd;
      hist_addr[0] = buf_addr;
      pr = hist_rd[LT-1];
      pa = hist_addr[LT-1];
      @(posedge clk);
      #1;
      for (int j = 0; j < NK; j++) begin
        if (pr && (pa < BL'(MAXL))) prod_i[j*PW +: PW] = prodtab[j][pa];
        else                        prod_i[j*PW +: PW] = $urandom;
      end
    end
  end

  // Consumer: random backpressure unless a hold test is stalling it.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: latency on result rise, stability while held, data on handshake.
  initial begin
    logic          prev_rv;
    logic [RW-1:0] held;
    prev_rv = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev_rv) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", RW'(1), RW'(0));
        end else begin
          check("latency", RW'(cyc), RW'(sbq[0].due));
          check("hold_dsp_clk_en", RW'(dsp_clk_en), RW'(0));
          check("hold_cmd_ready", RW'(cmd_ready), RW'(0));
        end
        held = res_data;
      end else if (res_valid) begin
        check("hold_stable", res_data, held);
      end
      if (res_valid && res_ready && (sbq.size() > 0)) begin
        check("res_data", res_data, sbq[0].data);
        void'(sbq.pop_front());
      end
      prev_rv = res_valid;
    end
  end

  // Offer one job once the DUT is idle. abort_at / rst_at give the cycle after
  // acceptance in which to abort or pulse reset (0 = never).
  task automatic run_job(input int len, input int abort_at, input int rst_at);
    bit got;
    int c;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", RW'(0), RW'(1));
      return;
    end
    for (int j = 0; j < NK; j++)
      for (int a = 0; a < MAXL; a++)
        prodtab[j][a] = stage_tab[j][a];
    cmd_valid = 1'b1;
    cmd_len   = BL'(len);
    c = cyc;
    if (abort_at == 0 && rst_at == 0) begin
      sbq.push_back('{data: model(len), due: (len == 0) ? c + 1 : c + len + LT + 1});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = $urandom;
    if (abort_at > 0) begin
      repeat (abort_at - 1) begin
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_to_idle", RW'(cmd_ready), RW'(1));
      check("abort_no_result", RW'(res_valid), RW'(0));
    end
    if (rst_at > 0) begin
      repeat (rst_at - 1) begin
        @(posedge clk);
        #1;
      end
      rstn = 1'b0;
      #1;
      check("rst_cmd_ready", RW'(cmd_ready), RW'(0));
      check("rst_buf_rd", RW'(buf_rd), RW'(0));
      check("rst_buf_addr", RW'(buf_addr), RW'(0));
      check("rst_dsp_clk_en", RW'(dsp_clk_en), RW'(0));
      check("rst_res_valid", RW'(res_valid), RW'(0));
      check("rst_res_data", res_data, RW'(0));
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_ready", RW'(cmd_ready), RW'(1));
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < NK; j++)
      for (int a = 0; a < MAXL; a++)
        stage_tab[j][a] = $urandom;
  endtask

  initial begin
    bit got;
    int len;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    abort     = 1'b0;
    fill_random();
    for (int j = 0; j < NK; j++)
      for (int a = 0; a < MAXL; a++)
        prodtab[j][a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", RW'(cmd_ready), RW'(0));
    check("reset_dsp_clk_en", RW'(dsp_clk_en), RW'(0));
    check("reset_res_valid", RW'(res_valid), RW'(0));
    check("reset_res_data", res_data, RW'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", RW'(cmd_ready), RW'(1));

    // Mixed-sign products and near-full-scale products.
    fill_random();
    for (int a = 0; a < 4; a++) begin
      stage_tab[0][a] = PW'(a + 1);
      stage_tab[1][a] = -32'sd1;
      stage_tab[2][a] = 32'sh7FFF_FFFF;
    end
    run_job(4, 0, 0);

    // Single-step job with a negative product on every lane.
    fill_random();
    for (int j = 0; j < NK; j++) stage_tab[j][0] = -32'sd5;
    run_job(1, 0, 0);

    // Empty job.
    fill_random();
    run_job(0, 0, 0);

    // Abort during issue, then a short job.
    fill_random();
    run_job(8, 3, 0);
    fill_random();
    run_job(2, 0, 0);

    // Abort coinciding with the final product.
    fill_random();
    run_job(3, 3 + LT, 0);

    // Long hold with the consumer stalled.
    fill_random();
    run_job(3, 0, 0);
    stall = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("hold_reached", RW'(got), RW'(1));
    repeat (20) @(negedge clk);
    check("stall_res_valid", RW'(res_valid), RW'(1));
    check("stall_cmd_ready", RW'(cmd_ready), RW'(0));
    check("stall_dsp_clk_en", RW'(dsp_clk_en), RW'(0));
    stall = 1'b0;

    // Reset pulse while draining.
    fill_random();
    run_job(6, 0, 6 + 2);

    // Randomized jobs, some aborted.
    for (int n = 0; n < 40; n++) begin
      fill_random();
      len = $urandom_range(0, 12);
      if (len > 0 && $urandom_range(0, 5) == 0)
        run_job(len, $urandom_range(1, len + LT), 0);
      else
        run_job(len, 0, 0);
    end

    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !res_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("scoreboard_drained", RW'(sbq.size()), RW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
